regfile_read_arbiter: RTL and testbench

- Shares the single 64-bit, 32-entry register-file read port among NUM_REQ requesters.
- The read port is the 32:1 bit-sliced mux: a 5-bit select in, 64-bit data out.
- Arbitration is round-robin with a valid/ready request handshake.
- The select is registered and the read data is captured into a response register, giving fixed 2-cycle latency at a throughput of one read per cycle.
- Sits between the datapath read clients (decode operand fetch, debug/scan port) and the register-file read mux.

---
 rtl/regfile_read_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_read_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the single register-file read port among NUM_REQ requesters.
// Latency: fixed 2 cycles from handshake to rsp_valid, one read per cycle sustained.
// Backpressure: requests are held off by req_ready; responses cannot be stalled.
//
// Ports:
//   clk, reset_n      rising-edge clock, synchronous active-low reset
//   req_valid/addr    per-requester read requests, addr packed ADDR_W bits per requester
//   req_ready         one-hot grant (handshake = req_valid & req_ready)
//   rf_sel / rf_data  registered select to the read mux, combinational mux data back
//   rsp_valid/data    one-hot one-cycle response strobe with registered read data
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rf_sel,
    input  logic [DATA_W-1:0]         rf_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_REQ - 1);

    // Priority pointer and pipeline state
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] rf_sel_q, rf_sel_d;
    logic              s1_v_q, s1_v_d;
    logic [PTR_W-1:0]  s1_id_q, s1_id_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Arbitration results
    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_id;
    logic [PTR_W:0]    scan_idx;
    logic [ADDR_W-1:0] gnt_addr;

    // Scan from ptr upward with wraparound; the first valid requester wins.
    // The scan index is one bit wider so ptr+k never overflows before the wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!gnt_found && req_valid[scan_idx[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx[PTR_W-1:0];
            end
        end
        // No grants while reset is held, even if requests are pending.
        if (!reset_n) begin
            gnt_found = 1'b0;
        end
    end

    // One-hot ready and AND-OR selection of the granted address.
    always_comb begin
        req_ready = '0;
        gnt_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && (gnt_id == PTR_W'(i))) begin
                req_ready[i] = 1'b1;
                gnt_addr     = gnt_addr | req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state: pointer, stage 1 (select) and stage 2 (response capture).
    always_comb begin
        ptr_d       = ptr_q;
        rf_sel_d    = rf_sel_q;
        s1_v_d      = 1'b0;
        s1_id_d     = s1_id_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        // A ready bit only rises on a valid request, so gnt_found is the handshake.
        if (gnt_found) begin
            ptr_d    = (gnt_id == LAST_ID) ? '0 : gnt_id + PTR_W'(1);
            rf_sel_d = gnt_addr;
            s1_v_d   = 1'b1;
            s1_id_d  = gnt_id;
        end
        // Without a handshake rf_sel holds so the read mux does not toggle.

        if (s1_v_q) begin
            rsp_data_d = rf_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (s1_id_q == PTR_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            rf_sel_q    <= '0;
            s1_v_q      <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rf_sel_q    <= rf_sel_d;
            s1_v_q      <= s1_v_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rf_sel   = rf_sel_q;
    // A response already registered when reset arrives is suppressed at once,
    // so in-flight reads are discarded rather than leaking out during reset.
    assign rsp_valid = reset_n ? rsp_valid_q : '0;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomized and directed stimulus for regfile_read_arbiter with a round-robin reference model.
// Expected responses are queued at issue time and checked by an independent monitor.
// Responses are checked for requester, data and exact arrival cycle.
module tb_regfile_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     rf_sel;
    logic [DW-1:0]     rf_data;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;

    logic [DW-1:0] rf_mem [32];
    assign rf_data = rf_mem[rf_sel];

    always #5 clk = ~clk;

    regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rf_sel    (rf_sel),
        .rf_data   (rf_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    int            ptr_m = 0;
    logic [AW-1:0] sel_m = '0;
    bit            sel_known = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [N*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [N*AW-1:0] r;
        r = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        return r;
    endfunction

    // One clock cycle of stimulus: drive, check grant and select against the model,
    // then advance the model by what this cycle does.
    task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic rst_n);
        int g;
        int idx;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] addr;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        reset_n   = rst_n;
        #1;
        g = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checks++;
        if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL req_ready cyc=%0d got=%b expected=%b", cyc, req_ready, exp_rdy);
        end
        if (sel_known) begin
            checks++;
            if (rf_sel !== sel_m) begin
                failures++;
                $display("FAIL rf_sel cyc=%0d got=%0d expected=%0d", cyc, rf_sel, sel_m);
            end
        end
        if (!rst_n) begin
            ptr_m     = 0;
            sel_m     = '0;
            sel_known = 1;
            exp_q.delete();
        end else if (g >= 0) begin
            addr   = a[g*AW +: AW];
            sel_m  = addr;
            ptr_m  = (g + 1) % N;
            e.id   = g;
            e.data = rf_mem[addr];
            e.due  = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    // Response monitor, decoupled from stimulus.
    logic [DW-1:0] last_data_m = '0;
    bit            data_known = 0;
    bit            prev_rst = 0;

    initial begin
        exp_t e;
        logic [N-1:0] exp_oh;
        forever begin
            @(negedge clk);
            #3;
            if (!reset_n) begin
                checks++;
                if (rsp_valid !== '0) begin
                    failures++;
                    $display("FAIL rsp_valid_in_reset cyc=%0d got=%b expected=0", cyc, rsp_valid);
                end
                if (prev_rst) begin
                    checks++;
                    if (rsp_data !== '0) begin
                        failures++;
                        $display("FAIL rsp_data_reset cyc=%0d got=%h expected=0", cyc, rsp_data);
                    end
                end
                last_data_m = '0;
                data_known  = 1;
            end else if (rsp_valid !== '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp cyc=%0d got=%b expected=none", cyc, rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    exp_oh = '0;
                    exp_oh[e.id] = 1'b1;
                    if (rsp_valid !== exp_oh || rsp_data !== e.data || cyc != e.due) begin
                        failures++;
                        $display("FAIL rsp cyc=%0d got=%b/%h expected=%b/%h at cyc %0d",
                                 cyc, rsp_valid, rsp_data, exp_oh, e.data, e.due);
                    end
                    last_data_m = e.data;
                end
            end else begin
                if (data_known) begin
                    checks++;
                    if (rsp_data !== last_data_m) begin
                        failures++;
                        $display("FAIL rsp_data_hold cyc=%0d got=%h expected=%h", cyc, rsp_data, last_data_m);
                    end
                end
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_rsp cyc=%0d got=none expected=id%0d due %0d", cyc, e.id, e.due);
                end
            end
            prev_rst = !reset_n;
        end
    end

    initial begin
        logic [N-1:0]    v;
        logic [N*AW-1:0] a;
        logic            r;
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        for (int i = 1; i <= 4; i++) rf_mem[i] = {32'hA5A5_0000, 32'(i)};
        rf_mem[7]  = 64'hDEAD_BEEF_0000_0007;
        rf_mem[12] = 64'h1234_5678_9ABC_000C;
        rf_mem[31] = 64'hFFFF_0000_FFFF_001F;

        // Reset with all requesters asserting.
        repeat (3) step(4'b1111, pack4(1, 2, 3, 4), 1'b0);
        step(4'b1111, pack4(1, 2, 3, 4), 1'b1);   // first grant to requester 0
        repeat (3) step(4'b0000, '0, 1'b1);

        // Single read latency from requester 2.
        step(4'b0100, pack4(0, 0, 7, 0), 1'b1);
        repeat (3) step(4'b0000, '0, 1'b1);

        // Round-robin fairness with all four valid.
        repeat (8) step(4'b1111, pack4(1, 2, 3, 4), 1'b1);
        repeat (3) step(4'b0000, '0, 1'b1);

        // Pointer wrap and skip.
        step(4'b1000, pack4(0, 0, 0, 31), 1'b1);
        repeat (3) step(4'b0110, pack4(0, 5, 6, 0), 1'b1);
        repeat (3) step(4'b0000, '0, 1'b1);

        // Idle hold after a single read of reg 12.
        step(4'b0001, pack4(12, 0, 0, 0), 1'b1);
        repeat (5) step(4'b0000, '0, 1'b1);

        // Reset mid-flight.
        step(4'b0010, pack4(0, 3, 0, 0), 1'b1);
        step(4'b1000, pack4(0, 0, 0, 4), 1'b1);
        step(4'b1111, pack4(1, 2, 3, 4), 1'b0);
        step(4'b1100, pack4(0, 0, 9, 10), 1'b1);  // ptr back at 0: lowest valid is 2
        repeat (3) step(4'b0000, '0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            v = N'($urandom_range(0, 15));
            a = (N*AW)'({$urandom, $urandom});
            r = ($urandom_range(0, 63) != 0);
            step(v, a, r);
        end
        repeat (4) step(4'b0000, '0, 1'b1);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
